sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider_if.sv | 36 +++
 rtl/sequential_divider.sv | 120 ++++++++++++
 tb/tb_sequential_divider.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// Request/result bundle for the sequential divider: operands and start from the
// requester, status and results back from the divider.
interface sequential_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  ready,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output ready,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, N iterations per
// operation, results held until the next completion.
module sequential_divider #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  sequential_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [N-1:0]  work_q, work_d;
  logic [N:0]    prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;

  logic [N+1:0]  step_wide;
  logic          step_ge;
  logic [N:0]    step_rem;
  logic [N-1:0]  step_quo;

  // One restoring step; the extra headroom bit keeps the compare and the
  // subtraction exact for every operand value.
  always_comb begin
    step_wide = {prem_q, work_q[N-1]};
    step_ge   = (step_wide >= {2'b00, divisor_q});
    step_rem  = step_ge ? (N+1)'(step_wide - {2'b00, divisor_q}) : step_wide[N:0];
    step_quo  = {work_q[N-2:0], step_ge};
  end

  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    work_d      = work_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    busy_d      = 1'b0;
    ready_d     = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = BUSY;
          divisor_d = bus.divisor;
          work_d    = bus.dividend;
          prem_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      BUSY: begin
        prem_d = step_rem;
        work_d = step_quo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d     = DONE;
          ready_d     = 1'b1;
          quotient_d  = step_quo;
          remainder_d = step_rem[N-1:0];
          dbz_d       = (divisor_q == '0);
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      work_q      <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      work_q      <= work_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider (N=4): directed operations push
// expected results, a negedge monitor pops and compares on every ready pulse.
module tb_sequential_divider;
  localparam int N = 4;

  logic clk;
  logic rst;

  sequential_divider_if #(.N(N)) bus ();

  sequential_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic         dbz;
  } result_t;

  result_t sb[$];
  int checks      = 0;
  int failures    = 0;
  int ready_total = 0;
  int exp_total   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int q, input int r, input int z);
    result_t e;
    e.quo = q[N-1:0];
    e.rem = r[N-1:0];
    e.dbz = z[0];
    sb.push_back(e);
    exp_total++;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    result_t e;
    if (!rst && bus.ready) begin
      ready_total++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(bus.quotient), int'(e.quo));
        check("remainder", int'(bus.remainder), int'(e.rem));
        check("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
        $display("result q=%0d r=%0d dbz=%0d", bus.quotient, bus.remainder, bus.div_by_zero);
      end
    end
  end

  // One operation; a stray start with other operands is pulsed mid-BUSY and
  // must have no effect on the running result.
  task automatic run_op(input int a, input int b, input int eq, input int er, input int ez);
    int k;
    int busy_cnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a[N-1:0];
    bus.divisor  = b[N-1:0];
    push_exp(eq, er, ez);
    $display("op %0d/%0d expect q=%0d r=%0d dbz=%0d", a, b, eq, er, ez);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (!bus.ready && k < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.start    = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ready_latency", k, N);
    check("busy_cycles", busy_cnt, N);
    check("busy_in_done", int'(bus.busy), 0);
    @(negedge clk);
    check("ready_one_cycle", int'(bus.ready), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_ready"}, int'(bus.ready), 0);
    check({tag, "_quotient"}, int'(bus.quotient), 0);
    check({tag, "_remainder"}, int'(bus.remainder), 0);
    check({tag, "_dbz"}, int'(bus.div_by_zero), 0);
  endtask

  task automatic reset_mid_busy();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd4;
    $display("op 13/4 aborted by reset mid-busy");
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_before_abort", int'(bus.busy), 1);
    #2;
    rst       = 1'b1;
    bus.start = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_zero_outputs("held_rst");
    end
    rst       = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic back_to_back();
    int k;
    int n;
    int prev;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd14;
    bus.divisor  = 4'd3;
    for (int i = 0; i < 3; i++) push_exp(4, 2, 0);
    $display("op 14/3 x3 back-to-back expect q=4 r=2");
    k = 0;
    n = 0;
    prev = 0;
    while (n < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.ready) begin
        if (n > 0) check("b2b_spacing", k - prev, N + 2);
        prev = k;
        n++;
        if (n == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", n, 3);
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 4'd5;
    bus.divisor  = 4'd1;
    @(negedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst       = 1'b0;
    bus.start = 1'b0;

    run_op(13, 4, 3, 1, 0);
    run_op(3, 9, 0, 3, 0);
    run_op(15, 1, 15, 0, 0);
    run_op(7, 0, 15, 7, 1);
    reset_mid_busy();
    run_op(9, 2, 4, 1, 0);
    run_op(0, 5, 0, 0, 0);
    run_op(15, 15, 1, 0, 0);
    run_op(8, 3, 2, 2, 0);
    run_op(12, 0, 15, 12, 1);
    back_to_back();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("ready_pulse_total", ready_total, exp_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
